// File: rtl/madd_ctrl_pkg.sv
// madd_ctrl_pkg: shared defines for the multiply-accumulate controller.
// Stall/bus types, op and state encodings, ALU-op codes.
package madd_ctrl_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic Stop       = 1'b1;
  localparam logic NoStop     = 1'b0;
  localparam int   StallMem   = 4;

  typedef logic [5:0]  stall_signal_t;
  typedef logic [63:0] double_reg_bus_t;

  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  typedef enum logic [1:0] {
    OP_MADD  = 2'b00,
    OP_MADDU = 2'b01,
    OP_MSUB  = 2'b10,
    OP_MSUBU = 2'b11
  } madd_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_ACC  = 2'b10
  } madd_state_e;

  // op[0] selects unsigned multiply, op[1] selects subtract
  function automatic logic op_is_signed(madd_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_sub(madd_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/madd_ctrl_mul.sv
// mul32x32: 32x32->64 multiplier, signed or unsigned, purely combinational.
// Ports: a, b operands; is_signed selects mode; p low 64 bits of product.
module mul32x32 (
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);

  logic signed [32:0] ax;
  logic signed [32:0] bx;
  logic signed [65:0] full;

  // a 33rd bit turns unsigned operands into non-negative signed ones
  assign ax   = {is_signed & a[31], a};
  assign bx   = {is_signed & b[31], b};
  assign full = ax * bx;
  assign p    = full[63:0];

endmodule

// File: rtl/madd_ctrl.sv
// madd_ctrl: multi-cycle MADD/MADDU/MSUB/MSUBU sequencer (IDLE->MUL->ACC).
// Ports: clk, rst (sync high), start_i, op_i, opdata1_i, opdata2_i,
// hilo_i, stall_i, flush_i -> stallreq_o, whilo_o, hi_o, lo_o, illegal_o.
// MACC_SUB_EN defined: MSUB/MSUBU legal; otherwise op_i[1]=1 is illegal.
module madd_ctrl
  import madd_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [31:0]     opdata1_i,
  input  logic [31:0]     opdata2_i,
  input  double_reg_bus_t hilo_i,
  input  stall_signal_t   stall_i,
  input  logic            flush_i,
  output logic            stallreq_o,
  output logic            whilo_o,
  output logic [31:0]     hi_o,
  output logic [31:0]     lo_o,
  output logic            illegal_o
);

  madd_state_e     state_q;
  madd_state_e     state_d;
  madd_op_e        op_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  double_reg_bus_t prod_q;
  double_reg_bus_t prod_d;
  double_reg_bus_t result;

  logic hold;
  logic legal;
  logic idle;
  logic accept;
  logic unused_stall;

  assign hold = (stall_i[StallMem] == Stop);
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

`ifdef MACC_SUB_EN
  assign legal = 1'b1;
`else
  assign legal = ~op_i[1];
`endif

  assign idle   = (state_q == S_IDLE);
  assign accept = idle & start_i & legal;

  mul32x32 u_mul (
    .is_signed (op_is_signed(op_q)),
    .a         (a_q),
    .b         (b_q),
    .p         (prod_d)
  );

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else if (!hold) begin
      unique case (state_q)
        S_IDLE:  state_d = accept ? S_MUL : S_IDLE;
        S_MUL:   state_d = S_ACC;
        S_ACC:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // hilo_i is read here, in ACC, so a forwarded value is used
  always_comb begin
    result = hilo_i + prod_q;
    if (op_is_sub(op_q)) begin
      result = hilo_i - prod_q;
    end
  end

  always_comb begin
    stallreq_o = accept | (state_q == S_MUL);
    whilo_o    = (state_q == S_ACC) & ~hold
               & ~flush_i & ~rst;
    illegal_o  = idle & start_i & ~legal
               & ~flush_i & ~rst;
    {hi_o, lo_o} = whilo_o ? result : '0;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= S_IDLE;
      op_q    <= OP_MADD;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_MADD;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else if (!hold) begin
      state_q <= state_d;
      if (accept) begin
        op_q <= madd_op_e'(op_i);
        a_q  <= opdata1_i;
        b_q  <= opdata2_i;
      end
      if (state_q == S_MUL) begin
        prod_q <= prod_d;
      end
    end
  end

endmodule
